// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encodings, lamp colours and lamp decode for the intersection controller
package traffic_pkg;

  typedef enum logic [2:0] {
    MG    = 3'd0,
    MY    = 3'd1,
    AR1   = 3'd2,
    SG    = 3'd3,
    SY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
  } lamps_t;

  function automatic lamps_t lamp_decode(input state_t st, input logic flash_phase);
    lamps_t l;
    l = '{main: RED, side: RED};
    case (st)
      MG:      l = '{main: GREEN,  side: RED};
      MY:      l = '{main: YELLOW, side: RED};
      SG:      l = '{main: RED,    side: GREEN};
      SY:      l = '{main: RED,    side: YELLOW};
      FLASH:   l = flash_phase ? '{main: YELLOW, side: RED} : '{main: DARK, side: DARK};
      default: l = '{main: RED,    side: RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_ctrl_param_if.sv
// rtl/traffic_ctrl_param_if.sv - sensor inputs and lamp/display outputs of the intersection controller
interface traffic_ctrl_param_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       ped_req;
  logic [1:0]       car_det;
  logic             night;
  logic             demand_mode;
  logic [2:0]       lights_main;
  logic [2:0]       lights_side;
  logic [CNT_W-1:0] countdown;
  logic [2:0]       state;
  logic             road_light;
  logic             tick;

  modport master (
    output ped_req, car_det, night, demand_mode,
    input  lights_main, lights_side, countdown, state, road_light, tick
  );

  modport slave (
    input  ped_req, car_det, night, demand_mode,
    output lights_main, lights_side, countdown, state, road_light, tick
  );
endinterface

// File: rtl/input_sync.sv
// rtl/input_sync.sv - 2-flop synchroniser with optional rising-edge strobe
module input_sync #(
  parameter int WIDTH   = 1,
  parameter bit SYNC_EN = 1'b1,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise
);

  generate
    if (SYNC_EN) begin : g_sync
      logic [WIDTH-1:0] meta_q;
      logic [WIDTH-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= async_in;
          sync_q <= meta_q;
        end
      end
      assign sync_out = sync_q;
    end else begin : g_bypass
      assign sync_out = async_in;
    end

    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] prev_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= sync_out;
      end
      assign rise = sync_out & ~prev_q;
    end else begin : g_no_edge
      assign rise = '0;
    end
  endgenerate

endmodule

// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - parametrised main/side road controller with demand, all-red and night flash
import traffic_pkg::*;

module traffic_ctrl_param #(
  parameter int CLK_HZ   = 12000000,
  parameter int TICK_HZ  = 1,
  parameter int CNT_W    = 8,
  parameter int T_MG     = 15,
  parameter int T_MIN_MG = 5,
  parameter int T_MY     = 3,
  parameter int T_SG     = 8,
  parameter int T_SY     = 3,
  parameter int T_AR     = 1,
  parameter bit SYNC_EN  = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_ctrl_param_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  localparam logic [CNT_W-1:0] LD_MG     = CNT_W'(T_MG - 1);
  localparam logic [CNT_W-1:0] LD_MIN_MG = CNT_W'(T_MIN_MG - 1);
  localparam logic [CNT_W-1:0] LD_MY     = CNT_W'(T_MY - 1);
  localparam logic [CNT_W-1:0] LD_SG     = CNT_W'(T_SG - 1);
  localparam logic [CNT_W-1:0] LD_SY     = CNT_W'(T_SY - 1);
  localparam logic [CNT_W-1:0] LD_AR     = CNT_W'(T_AR - 1);

  logic [1:0] ped_sync_unused, ped_rise, car_sync, car_rise_unused;
  logic       night_s, night_rise_unused;

  input_sync #(.WIDTH(2), .SYNC_EN(SYNC_EN), .EDGE_EN(1'b1)) u_ped_sync (
    .clk(clk), .rst_n(rst_n), .async_in(bus.ped_req), .sync_out(ped_sync_unused), .rise(ped_rise)
  );
  input_sync #(.WIDTH(2), .SYNC_EN(SYNC_EN), .EDGE_EN(1'b0)) u_car_sync (
    .clk(clk), .rst_n(rst_n), .async_in(bus.car_det), .sync_out(car_sync), .rise(car_rise_unused)
  );
  input_sync #(.WIDTH(1), .SYNC_EN(SYNC_EN), .EDGE_EN(1'b0)) u_night_sync (
    .clk(clk), .rst_n(rst_n), .async_in(bus.night), .sync_out(night_s), .rise(night_rise_unused)
  );

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             mode_q, mode_d;
  logic             demand_q;
  logic             road_light_q;
  lamps_t           lamps_q, lamps_d;
  logic             last;

  assign last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    // An upset into encoding 7 recovers without waiting for a tick.
    if (tick || state_q == state_t'(3'd7)) begin
      case (state_q)
        MG: begin
          if (night_s || (last && (!mode_q || demand_q))) begin
            state_d = MY;
            cnt_d   = LD_MY;
          end else if (!last) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        MY: begin
          if (!last) cnt_d = cnt_q - CNT_W'(1);
          else if (night_s) begin
            // FLASH entry counts as the first toggle, so the lamps open on yellow.
            state_d = FLASH;
            cnt_d   = '0;
            phase_d = 1'b1;
          end else begin
            state_d = AR1;
            cnt_d   = LD_AR;
          end
        end
        AR1: begin
          if (!last) cnt_d = cnt_q - CNT_W'(1);
          else begin state_d = SG; cnt_d = LD_SG; end
        end
        SG: begin
          if (!last) cnt_d = cnt_q - CNT_W'(1);
          else begin state_d = SY; cnt_d = LD_SY; end
        end
        SY: begin
          if (!last) cnt_d = cnt_q - CNT_W'(1);
          else begin state_d = AR2; cnt_d = LD_AR; end
        end
        AR2: begin
          if (!last) cnt_d = cnt_q - CNT_W'(1);
          else begin
            state_d = MG;
            mode_d  = bus.demand_mode;
            cnt_d   = bus.demand_mode ? LD_MIN_MG : LD_MG;
          end
        end
        FLASH: begin
          cnt_d = '0;
          if (!night_s) begin
            state_d = AR2;
            cnt_d   = LD_AR;
            phase_d = 1'b0;
          end else begin
            phase_d = ~phase_q;
          end
        end
        default: begin
          state_d = MG;
          cnt_d   = LD_MG;
          phase_d = 1'b0;
        end
      endcase
    end
    lamps_d = lamp_decode(state_d, phase_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MG;
      cnt_q   <= bus.demand_mode ? LD_MIN_MG : LD_MG;
      mode_q  <= bus.demand_mode;
      phase_q <= 1'b0;
      lamps_q <= '{main: GREEN, side: RED};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      lamps_q <= lamps_d;
    end
  end

  // Clear wins on the SG entry tick, so a request arriving on that very tick is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      demand_q     <= 1'b0;
      road_light_q <= 1'b0;
    end else begin
      road_light_q <= night_s;
      if (tick && state_q != SG && state_d == SG)
        demand_q <= 1'b0;
      else if (((|ped_rise) || (|car_sync)) && state_q != SG && state_q != SY)
        demand_q <= 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.countdown   = cnt_q;
  assign bus.lights_main = lamps_q.main;
  assign bus.lights_side = lamps_q.side;
  assign bus.road_light  = road_light_q;
  assign bus.tick        = tick;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb/tb_traffic_ctrl_param.sv - scoreboard bench for traffic_ctrl_param
module tb_traffic_ctrl_param;

  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001, O = 3'b000;
  localparam logic [2:0] S_MG = 3'd0, S_MY = 3'd1, S_AR1 = 3'd2, S_SG = 3'd3,
                         S_SY = 3'd4, S_AR2 = 3'd5, S_FL = 3'd6;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] cd;
    logic [2:0] lm;
    logic [2:0] ls;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   tick_gap = 0;
  exp_t sb[$];

  traffic_ctrl_param_if #(.CNT_W(8)) bus ();

  traffic_ctrl_param #(
    .CLK_HZ(10), .TICK_HZ(1), .CNT_W(8), .T_MG(4), .T_MIN_MG(2), .T_MY(2),
    .T_SG(3), .T_SY(2), .T_AR(1), .SYNC_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input logic [2:0] st, input logic [7:0] cd,
                               input logic [2:0] lm, input logic [2:0] ls, input int n = 1);
    for (int i = 0; i < n; i++) sb.push_back('{st: st, cd: cd, lm: lm, ls: ls});
  endfunction

  task automatic next_tick(output bit timeout);
    int n;
    n = 0;
    timeout = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.tick === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    tick_gap = n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.state !== S_MG) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", bus.state, S_MG); end
    vectors++; if (bus.countdown !== 8'd3) begin miscompares++; $display("FAIL reset_countdown: got %0d want 3", bus.countdown); end
    vectors++; if (bus.lights_main !== G) begin miscompares++; $display("FAIL reset_main: got %b want %b", bus.lights_main, G); end
    vectors++; if (bus.lights_side !== R) begin miscompares++; $display("FAIL reset_side: got %b want %b", bus.lights_side, R); end
    vectors++; if (bus.tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
    vectors++; if (bus.road_light !== 1'b0) begin miscompares++; $display("FAIL reset_road_light: got %b want 0", bus.road_light); end
  endtask

  task automatic test_timed();
    bit   to;
    exp_t e;
    push(S_MG, 2, G, R); push(S_MG, 1, G, R); push(S_MG, 0, G, R);
    push(S_MY, 1, Y, R); push(S_MY, 0, Y, R); push(S_AR1, 0, R, R);
    push(S_SG, 2, R, G); push(S_SG, 1, R, G); push(S_SG, 0, R, G);
    push(S_SY, 1, R, Y); push(S_SY, 0, R, Y); push(S_AR2, 0, R, R);
    push(S_MG, 3, G, R);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL timed_tick_timeout: got none want tick within 40 clk"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL timed_phase: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
      vectors++;
      if (tick_gap !== 9) begin miscompares++; $display("FAIL timed_tick_period: got %0d want 9 clk after previous tick+1", tick_gap); end
      vectors++;
      if (bus.tick !== 1'b0) begin miscompares++; $display("FAIL timed_tick_width: got %b want 0", bus.tick); end
    end
  endtask

  task automatic test_demand();
    bit   to;
    exp_t e;
    bus.demand_mode = 1'b1;
    push(S_MG, 2, G, R); push(S_MG, 1, G, R); push(S_MG, 0, G, R);
    push(S_MY, 1, Y, R); push(S_MY, 0, Y, R); push(S_AR1, 0, R, R);
    push(S_SG, 2, R, G); push(S_SG, 1, R, G); push(S_SG, 0, R, G);
    push(S_SY, 1, R, Y); push(S_SY, 0, R, Y); push(S_AR2, 0, R, R);
    push(S_MG, 1, G, R); push(S_MG, 0, G, R); push(S_MG, 0, G, R, 20);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL demand_idle_timeout: got none want tick"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL demand_idle: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
    end
    bus.ped_req = 2'b10;
    repeat (3) @(negedge clk);
    bus.ped_req = 2'b00;
    push(S_MY, 1, Y, R); push(S_MY, 0, Y, R); push(S_AR1, 0, R, R); push(S_SG, 2, R, G);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL demand_ped_timeout: got none want tick"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL demand_ped: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
    end
    bus.ped_req = 2'b01;
    repeat (3) @(negedge clk);
    bus.ped_req = 2'b00;
    push(S_SG, 1, R, G); push(S_SG, 0, R, G); push(S_SY, 1, R, Y); push(S_SY, 0, R, Y);
    push(S_AR2, 0, R, R); push(S_MG, 1, G, R); push(S_MG, 0, G, R); push(S_MG, 0, G, R, 5);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL demand_sg_ignore_timeout: got none want tick"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL demand_sg_ignore: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
    end
  endtask

  task automatic test_car_demand();
    bit   to;
    exp_t e;
    bus.demand_mode = 1'b0;
    bus.car_det = 2'b01;
    repeat (3) @(negedge clk);
    bus.car_det = 2'b00;
    push(S_MY, 1, Y, R); push(S_MY, 0, Y, R); push(S_AR1, 0, R, R);
    push(S_SG, 2, R, G); push(S_SG, 1, R, G); push(S_SG, 0, R, G);
    push(S_SY, 1, R, Y); push(S_SY, 0, R, Y); push(S_AR2, 0, R, R);
    push(S_MG, 3, G, R);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL car_demand_timeout: got none want tick"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL car_demand: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
    end
  endtask

  task automatic test_night();
    bit   to;
    exp_t e;
    bus.night = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.road_light !== 1'b1) begin miscompares++; $display("FAIL night_road_light: got %b want 1", bus.road_light); end
    push(S_MY, 1, Y, R); push(S_MY, 0, Y, R);
    push(S_FL, 0, Y, R); push(S_FL, 0, O, O); push(S_FL, 0, Y, R); push(S_FL, 0, O, O);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL night_flash_timeout: got none want tick"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL night_flash: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
    end
    bus.night = 1'b0;
    push(S_AR2, 0, R, R); push(S_MG, 3, G, R);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL night_exit_timeout: got none want tick"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL night_exit: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   to;
    exp_t e;
    push(S_MG, 2, G, R); push(S_MG, 1, G, R); push(S_MG, 0, G, R);
    push(S_MY, 1, Y, R); push(S_MY, 0, Y, R); push(S_AR1, 0, R, R); push(S_SG, 2, R, G);
    while (sb.size() > 0) begin
      next_tick(to);
      e = sb.pop_front();
      vectors++;
      if (to) begin miscompares++; $display("FAIL reset_mid_lead_timeout: got none want tick"); end
      else if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {e.st, e.cd, e.lm, e.ls}) begin
        miscompares++;
        $display("FAIL reset_mid_lead: got %0d/%0d/%b/%b want %0d/%0d/%b/%b", bus.state, bus.countdown,
                 bus.lights_main, bus.lights_side, e.st, e.cd, e.lm, e.ls);
      end
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side, bus.tick} !== {S_MG, 8'd3, G, R, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_values: got %0d/%0d/%b/%b/%b want 0/3/010/100/0", bus.state, bus.countdown,
               bus.lights_main, bus.lights_side, bus.tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_tick(to);
    vectors++;
    if (to || tick_gap !== 9) begin miscompares++; $display("FAIL reset_mid_tick_restart: got %0d want 9 clk to first tick", tick_gap); end
    vectors++;
    if ({bus.state, bus.countdown, bus.lights_main, bus.lights_side} !== {S_MG, 8'd2, G, R}) begin
      miscompares++;
      $display("FAIL reset_mid_first_tick: got %0d/%0d/%b/%b want 0/2/010/100", bus.state, bus.countdown,
               bus.lights_main, bus.lights_side);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ped_req = 2'b00;
    bus.car_det = 2'b00;
    bus.night = 1'b0;
    bus.demand_mode = 1'b0;
    test_reset();
    test_timed();
    test_demand();
    test_car_demand();
    test_night();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
- Parametrised two-road intersection controller: main road and side road.
- Successor to the fixed-timing crossroad controller, with these additions:
  - all phase durations and the tick rate set by parameters;
  - single clock domain with an internal tick enable (no derived clocks);
  - all-red clearance phases;
  - optional side-road demand mode, with latched pedestrian and car requests;
  - night flashing mode.
- Drives the lamp outputs, the road lighting and the remaining-time countdown shown on the segment display.

Parameters:
- CLK_HZ, 12000000: input clock frequency.
- TICK_HZ, 1: phase timing tick rate.
- CNT_W, 8: countdown width. Every T_* value must be ≥1 and <2^CNT_W.
- T_MG, 15: main green ticks (timed mode).
- T_MIN_MG, 5: minimum main green ticks (demand mode).
- T_MY, 3: main yellow ticks.
- T_SG, 8: side green ticks.
- T_SY, 3: side yellow ticks.
- T_AR, 1: all-red clearance ticks.
- SYNC_EN, 1: 1 inserts the 2-flop input synchronisers; 0 bypasses them (bench only).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- ped_req, in, 2: pedestrian buttons, async level, already debounced.
- car_det, in, 2: side-road car detectors, async level.
- night, in, 1: light-sensor dark indication, async level.
- demand_mode, in, 1: 0 = timed mode, 1 = demand mode. Quasi-static.
- lights_main, out, 3: {R,G,Y}.
- lights_side, out, 3: {R,G,Y}.
- countdown, out, CNT_W: ticks remaining in the phase, minus 1.
- state, out, 3: current state encoding.
- road_light, out, 1: road lighting on.
- tick, out, 1: one-clk tick strobe.

Behaviour:
- Tick generator:
  - Counter runs 0..CLK_HZ/TICK_HZ-1 and wraps.
  - tick is high for exactly one clk when the counter equals its maximum.
  - All FSM and countdown updates occur only on clk edges where tick=1.
- Inputs:
  - Each input passes through a 2-flop synchroniser.
  - ped_req uses a rising-edge detect after synchronisation.
  - car_det is used as a level.
- Demand latch:
  - Set on any clk with a ped_req rising edge, or car_det≠0.
  - Only set while state ∉ {SG, SY}.
  - Cleared on the tick entering SG.
  - A request on the entry tick itself is discarded.
- States: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, FLASH=6.
  - Encoding 7 is illegal: go to MG with countdown T_MG-1.
- Countdown:
  - On entry to state X, loaded with T_X-1.
  - Decrements on each tick.
  - The state transitions on the tick where countdown==0, so each state lasts exactly T_X ticks.
- Transitions at countdown==0:
  - MG→MY. In demand mode, MG loads T_MIN_MG-1, saturates at 0, and leaves only on a tick with countdown==0 and demand=1.
  - MY→FLASH if night, else AR1.
  - AR1→SG.
  - SG→SY.
  - SY→AR2.
  - AR2→MG.
- Night entry:
  - night=1 on a tick in MG forces MG→MY immediately, regardless of countdown.
  - In MY/AR1/SG/SY/AR2 the cycle completes normally; night is acted on in MG or at MY exit.
- FLASH:
  - countdown held at 0; a flash-phase bit toggles every tick.
  - lights_main = phase ? YELLOW : 000.
  - lights_side = phase ? RED : 000.
  - night=0 on a tick → AR2, with the phase bit cleared.
- Lamps (registered, updated on the same edge as state):
  - MG: main GREEN, side RED.
  - MY: main YELLOW, side RED.
  - AR1/AR2: RED/RED.
  - SG: main RED, side GREEN.
  - SY: main RED, side YELLOW.
  - Colour codes: RED=100, GREEN=010, YELLOW=001.
- road_light: registered copy of the synchronised night, updated every clk.
- Reset values:
  - state=MG, countdown=T_MG-1 (T_MIN_MG-1 if demand_mode=1 at release).
  - lights_main=010, lights_side=100.
  - tick=0, tick counter=0, demand=0, flash phase=0, road_light=0, synchronisers=0.
- Reset mid-operation: immediately returns to the reset values; no partial phase is completed.
- demand_mode changes take effect at the next MG entry.

Decomposition:
- Shared package traffic_pkg:
  - state encodings MG..FLASH;
  - colour constants RED/GREEN/YELLOW;
  - lamp-decode function state→{main, side}.
- One sub-module, input_sync:
  - parameter WIDTH;
  - 2-flop synchroniser plus optional rising-edge output;
  - async active-low reset;
  - instanced for ped_req, car_det and night.

Test Plan:
- Bench parameters: CLK_HZ=10, TICK_HZ=1, T_MG=4, T_MY=2, T_AR=1, T_SG=3, T_SY=2, T_MIN_MG=2, SYNC_EN=1.
- Timed cycle, demand_mode=0, night=0 → state sequence MG(4) MY(2) AR1(1) SG(3) SY(2) AR2(1) MG, in ticks. Tick every 10 clk. countdown reaches 0 on each final tick.
- Demand mode with no requests for 20 ticks → stays MG, countdown saturates at 0. A ped_req[1] pulse (3 clk) then gives MY on the next tick, and demand=0 after SG entry.
- ped_req pulse during SG → ignored. After SY, AR2, MG, it stays MG in demand mode.
- night=1 asserted in MG with countdown=3 → next tick MY, then FLASH. lights_main toggles 001/000 per tick, road_light=1 within 3 clk.
- night=0 in FLASH → next tick AR2 (RED/RED), then MG with countdown=T_MG-1=3.
- rst_n low for 1 clk during SG mid-tick → immediately MG, 010/100, countdown=3, tick counter restarts at 0.
